// File: rtl/seri_hex_gosterge.sv
// seri_hex_gosterge: turns a stream of received ASCII bytes into hex digits and
// shows them on an 8-digit multiplexed, active-low 7-segment display.
//
// Handshake: veriGecerli is a one-cycle strobe with no back-pressure. The byte on
// veriBayt is consumed on every clock edge where veriGecerli=1 and sifirlama=0.
// Its effect is visible on the following cycle.
module seri_hex_gosterge #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       saatDarbesi,
  input  logic       sifirlama,
  input  logic       veriGecerli,
  input  logic [7:0] veriBayt,
  output logic [7:0] etkin,
  output logic [7:0] display,
  output logic [3:0] kayitSayisi,
  output logic [7:0] hataSayaci
);

  // Segment pattern {dp,g,f,e,d,c,b,a}, active-low, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Digit n of a buffer lives in bits [4n+3:4n]; digit0 is the rightmost digit.
  logic [31:0] edit_q,  edit_d;
  logic [31:0] shown_q, shown_d;
  logic [3:0]  kayit_q, kayit_d;
  logic [3:0]  shown_cnt_q, shown_cnt_d;
  logic [7:0]  hata_q,  hata_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  etkin_q, etkin_d;
  logic [7:0]  disp_q,  disp_d;

  logic        is_hex;
  logic [3:0]  nibble;

  // ASCII hex character classification and nibble value.
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    if (veriBayt >= 8'h30 && veriBayt <= 8'h39) begin
      nibble = veriBayt[3:0];
    end else if ((veriBayt >= 8'h41 && veriBayt <= 8'h46) ||
                 (veriBayt >= 8'h61 && veriBayt <= 8'h66)) begin
      nibble = veriBayt[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Byte command decode: hex entry, backspace, clear, commit or reject.
  always_comb begin
    edit_d      = edit_q;
    kayit_d     = kayit_q;
    shown_d     = shown_q;
    shown_cnt_d = shown_cnt_q;
    hata_d      = hata_q;
    if (veriGecerli) begin
      if (is_hex) begin
        edit_d  = {edit_q[27:0], nibble};
        kayit_d = (kayit_q < 4'd8) ? kayit_q + 4'd1 : 4'd8;
      end else if (veriBayt == 8'h08) begin
        if (kayit_q != 4'd0) begin
          edit_d  = {4'h0, edit_q[31:4]};
          kayit_d = kayit_q - 4'd1;
        end
      end else if (veriBayt == 8'h58 || veriBayt == 8'h78) begin
        edit_d  = 32'h0;
        kayit_d = 4'd0;
      end else if (veriBayt == 8'h0D || veriBayt == 8'h0A) begin
        shown_d     = edit_q;
        shown_cnt_d = kayit_q;
      end else if (hata_q != 8'hFF) begin
        hata_d = hata_q + 8'd1;
      end
    end
  end

  // Scan timebase: prescaler wrap advances the scanned digit index.
  always_comb begin
    presc_d = presc_q + 16'd1;
    idx_d   = idx_q;
    if (presc_q == SCAN_DIV - 16'd1) begin
      presc_d = 16'd0;
      idx_d   = idx_q + 3'd1;
    end
  end

  // Output stage: enable for the scanned digit, segments or a leading blank.
  always_comb begin
    etkin_d = ~(8'b1 << idx_q);
    disp_d  = 8'hFF;
    if ({1'b0, idx_q} < shown_cnt_q) begin
      disp_d = seg7(shown_q[{idx_q, 2'b00} +: 4]);
    end
  end

  // State registers; reset dominates any byte strobe in the same cycle.
  always_ff @(posedge saatDarbesi) begin
    if (sifirlama) begin
      edit_q      <= 32'h0;
      shown_q     <= 32'h0;
      kayit_q     <= 4'd0;
      shown_cnt_q <= 4'd0;
      hata_q      <= 8'd0;
      presc_q     <= 16'd0;
      idx_q       <= 3'd0;
      etkin_q     <= 8'hFF;
      disp_q      <= 8'hFF;
    end else begin
      edit_q      <= edit_d;
      shown_q     <= shown_d;
      kayit_q     <= kayit_d;
      shown_cnt_q <= shown_cnt_d;
      hata_q      <= hata_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      etkin_q     <= etkin_d;
      disp_q      <= disp_d;
    end
  end

  assign etkin       = etkin_q;
  assign display     = disp_q;
  assign kayitSayisi = kayit_q;
  assign hataSayaci  = hata_q;

endmodule

// File: tb/tb_seri_hex_gosterge.sv
// Directed bench for seri_hex_gosterge with a short scan period.
module tb_seri_hex_gosterge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] byt = 8'h00;
  logic [7:0] etkin;
  logic [7:0] display;
  logic [3:0] kayit;
  logic [7:0] hata;

  int tests_run    = 0;
  int tests_failed = 0;

  seri_hex_gosterge #(.SCAN_DIV(16'd4)) dut (
    .saatDarbesi (clk),
    .sifirlama   (rst),
    .veriGecerli (vld),
    .veriBayt    (byt),
    .etkin       (etkin),
    .display     (display),
    .kayitSayisi (kayit),
    .hataSayaci  (hata)
  );

  // Clock: 10 ns period. Inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Drive one byte strobe; returns at the falling edge after it was consumed.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    vld = 1'b1;
    byt = b;
    @(negedge clk);
    vld = 1'b0;
    byt = 8'h00;
  endtask

  // Record the segment value seen for each digit over a bit more than one scan frame.
  task automatic capture_frame(output logic [63:0] frame, output logic ok);
    logic [7:0] seen;
    logic [7:0] m;
    seen  = 8'h00;
    frame = '1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        m = 8'b1 << i[2:0];
        if (etkin == ~m) begin
          frame[i*8 +: 8] = display;
          seen[i] = 1'b1;
        end
      end
    end
    ok = (seen == 8'hFF);
  endtask

  task automatic test_reset;
    logic [7:0] exp_e;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (etkin !== 8'hFF || display !== 8'hFF || kayit !== 4'd0 || hata !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_values: etkin=%h display=%h kayit=%0d hata=%0d, need FF FF 0 0",
               etkin, display, kayit, hata);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      exp_e = ~(8'b1 << ((k / 4) % 8));
      tests_run++;
      if (etkin !== exp_e || display !== 8'hFF) begin
        tests_failed++;
        $display("FAIL idle_scan[%0d]: etkin=%h display=%h, need %h FF", k, etkin, display, exp_e);
      end
    end
    tests_run++;
    if (kayit !== 4'd0 || hata !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_counts: kayit=%0d hata=%0d, need 0 0", kayit, hata);
    end
  endtask

  task automatic test_hex_entry;
    logic [63:0] f;
    logic ok;
    send_byte("1"); send_byte("2"); send_byte("a"); send_byte("B");
    tests_run++;
    if (kayit !== 4'd4) begin
      tests_failed++;
      $display("FAIL hex_count: kayit=%0d, need 4", kayit);
    end
    send_byte(8'h0D);
    capture_frame(f, ok);
    tests_run++;
    if (!ok || f !== 64'hFFFF_FFFF_F9A4_8883) begin
      tests_failed++;
      $display("FAIL hex_frame: frame=%h complete=%0d, need FFFFFFFFF9A48883 1", f, ok);
    end
  endtask

  task automatic test_overflow;
    logic [63:0] f;
    logic ok;
    logic [71:0] s;
    s = "123456789";
    for (int i = 8; i >= 0; i--) send_byte(s[i*8 +: 8]);
    send_byte(8'h0D);
    tests_run++;
    if (kayit !== 4'd8) begin
      tests_failed++;
      $display("FAIL overflow_count: kayit=%0d, need 8", kayit);
    end
    capture_frame(f, ok);
    tests_run++;
    if (!ok || f !== 64'hA4B0_9992_82F8_8090) begin
      tests_failed++;
      $display("FAIL overflow_frame: frame=%h complete=%0d, need A4B0999282F88090 1", f, ok);
    end
  endtask

  task automatic test_backspace;
    logic [63:0] f;
    logic ok;
    send_byte("X");
    tests_run++;
    if (kayit !== 4'd0) begin
      tests_failed++;
      $display("FAIL clear_count: kayit=%0d, need 0", kayit);
    end
    send_byte("5"); send_byte("6"); send_byte(8'h08); send_byte(8'h0D);
    tests_run++;
    if (kayit !== 4'd1) begin
      tests_failed++;
      $display("FAIL bs_count: kayit=%0d, need 1", kayit);
    end
    capture_frame(f, ok);
    tests_run++;
    if (!ok || f !== 64'hFFFF_FFFF_FFFF_FF92) begin
      tests_failed++;
      $display("FAIL bs_frame: frame=%h complete=%0d, need FFFFFFFFFFFFFF92 1", f, ok);
    end
    send_byte(8'h08); send_byte(8'h08);
    tests_run++;
    if (kayit !== 4'd0 || hata !== 8'd0) begin
      tests_failed++;
      $display("FAIL bs_at_zero: kayit=%0d hata=%0d, need 0 0", kayit, hata);
    end
  endtask

  task automatic test_errors;
    logic [63:0] f;
    logic ok;
    send_byte("G");
    tests_run++;
    if (hata !== 8'd1) begin
      tests_failed++;
      $display("FAIL err_first: hata=%0d, need 1", hata);
    end
    send_byte(8'h20);
    tests_run++;
    if (hata !== 8'd2) begin
      tests_failed++;
      $display("FAIL err_second: hata=%0d, need 2", hata);
    end
    for (int i = 0; i < 300; i++) send_byte(8'h7E);
    tests_run++;
    if (hata !== 8'hFF || kayit !== 4'd0) begin
      tests_failed++;
      $display("FAIL err_saturate: hata=%h kayit=%0d, need FF 0", hata, kayit);
    end
    capture_frame(f, ok);
    tests_run++;
    if (!ok || f !== 64'hFFFF_FFFF_FFFF_FF92) begin
      tests_failed++;
      $display("FAIL err_frame: frame=%h complete=%0d, need FFFFFFFFFFFFFF92 1", f, ok);
    end
  endtask

  task automatic test_reset_mid_stream;
    logic [63:0] f;
    logic ok;
    send_byte("1"); send_byte("2");
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b1;
    byt = "7";
    @(negedge clk);
    tests_run++;
    if (etkin !== 8'hFF || display !== 8'hFF || kayit !== 4'd0 || hata !== 8'd0) begin
      tests_failed++;
      $display("FAIL midreset_values: etkin=%h display=%h kayit=%0d hata=%0d, need FF FF 0 0",
               etkin, display, kayit, hata);
    end
    rst = 1'b0;
    vld = 1'b0;
    byt = 8'h00;
    @(negedge clk);
    tests_run++;
    if (etkin !== 8'hFE || display !== 8'hFF || kayit !== 4'd0) begin
      tests_failed++;
      $display("FAIL midreset_first: etkin=%h display=%h kayit=%0d, need FE FF 0",
               etkin, display, kayit);
    end
    send_byte(8'h0A);
    capture_frame(f, ok);
    tests_run++;
    if (!ok || f !== 64'hFFFF_FFFF_FFFF_FFFF || kayit !== 4'd0) begin
      tests_failed++;
      $display("FAIL midreset_dropped: frame=%h complete=%0d kayit=%0d, need all FF 1 0",
               f, ok, kayit);
    end
  endtask

  initial begin
    test_reset();
    test_hex_entry();
    test_overflow();
    test_backspace();
    test_errors();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
